// File: rtl/stream_byte_packer.sv
// stream_byte_packer: packs a valid/ready byte stream into little-endian
// words of BYTES bytes. A word closes when it is full or when in_last arrives,
// so a frame may end on a partial word; in that case out_keep marks the lanes
// that carry data and frame_err latches. One output register stage sits between
// the byte side and the word side. It reloads on the same edge it drains, so
// the packer sustains one word every BYTES cycles.
module stream_byte_packer #(
    parameter int BYTES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*BYTES-1:0]   out_data,
    output logic [BYTES-1:0]     out_keep,
    output logic                 out_last,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 frame_err
);

    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    // idx 0 means empty, and idx > 0 means partially filled. Lanes at or above
    // idx in acc are always zero.
    logic [IDX_W-1:0]        idx;
    logic [BYTES-1:0][7:0]   acc;
    logic [BYTES-1:0][7:0]   merged;
    logic [BYTES-1:0]        keep_mask;

    logic byte_xfer;
    logic word_xfer;
    logic at_end;
    logic closing;

    // The byte side is ready whenever the output register is free or being
    // drained on this edge. in_valid is deliberately left out of this term.
    assign in_ready  = !out_valid || out_ready;
    assign byte_xfer = in_valid && in_ready;
    assign word_xfer = out_valid && out_ready;
    assign at_end    = (idx == LAST_IDX);
    assign closing   = byte_xfer && (at_end || in_last);

    // Build the word that would be emitted if the current byte closes it.
    // Lanes below idx come from acc, the lane at idx takes in_data, and lanes
    // above idx are forced to zero.
    for (genvar l = 0; l < BYTES; l++) begin : g_lane
        assign merged[l]    = (IDX_W'(l) < idx)  ? acc[l] :
                              (IDX_W'(l) == idx) ? in_data : 8'h00;
        assign keep_mask[l] = (IDX_W'(l) <= idx);
    end

    // Accumulator and byte index. A closing byte empties the accumulator.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx <= '0;
            acc <= '0;
        end else if (closing) begin
            idx <= '0;
            acc <= '0;
        end else if (byte_xfer) begin
            acc[idx] <= in_data;
            idx      <= idx + IDX_W'(1);
        end
    end

    // Output register. A load takes priority over a drain, so a simultaneous
    // drain and load keeps out_valid high with no bubble. A plain drain keeps
    // the payload and only clears out_valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (closing) begin
            out_valid <= 1'b1;
            out_data  <= merged;
            out_keep  <= keep_mask;
            out_last  <= in_last;
        end else if (word_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Handshake counters. They wrap naturally modulo 2^CNT_W.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_cnt  <= '0;
            frame_cnt <= '0;
        end else if (word_xfer) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (out_last)
                frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    // Sticky flag: a frame ended before its word filled. Only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            frame_err <= 1'b0;
        else if (byte_xfer && in_last && !at_end)
            frame_err <= 1'b1;
    end

endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed and random bench for stream_byte_packer. A byte-level model pushes
// the expected words into a queue as the bytes are sent. A monitor pops and
// compares that queue on every output handshake.
module tb_stream_byte_packer;

    localparam int BYTES    = 4;
    localparam int CNT_W    = 16;
    localparam int LIS_SIZE = 16;
    localparam int W        = 8 * BYTES;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [BYTES-1:0] out_keep;
    logic             out_last;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_err;

    stream_byte_packer #(.BYTES(BYTES), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .word_cnt  (word_cnt),
        .frame_cnt (frame_cnt),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0]     data;
        logic [BYTES-1:0] keep;
        logic             last;
    } word_t;

    word_t    exp_q[$];
    longint   hs_t[$];
    int       total = 0;
    int       bad   = 0;
    logic [W-1:0] m_acc;
    int       m_idx;
    bit       m_err;
    int       m_words;
    int       m_frames;
    bit       rnd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc    = '0;
        m_idx    = 0;
        m_err    = 1'b0;
        m_words  = 0;
        m_frames = 0;
        exp_q.delete();
    endtask

    // Present one byte at posedge+1, wait (bounded) for in_ready, model it, and
    // return at posedge+1 after the transfer edge.
    task automatic send(input logic [7:0] d, input bit last);
        int    n = 0;
        word_t w;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clock);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            n++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        m_acc[8*m_idx +: 8] = d;
        if (m_idx == BYTES - 1 || last) begin
            w.data = m_acc;
            w.keep = BYTES'((1 << (m_idx + 1)) - 1);
            w.last = last;
            exp_q.push_back(w);
            if (m_idx != BYTES - 1) m_err = 1'b1;
            m_words++;
            if (last) m_frames++;
            m_acc = '0;
            m_idx = 0;
        end else begin
            m_idx++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        word_t mw;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rnd       = 1'b0;
        model_reset();

        // Monitor: a handshake happens on the next edge whenever both sides are
        // high at the negedge.
        fork
            forever begin
                @(negedge clock);
                if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                    hs_t.push_back(longint'($time));
                    total++;
                    assert (exp_q.size() != 0) else begin
                        bad++;
                        $error("FAIL spurious_word: observed=%0h expected=none", out_data);
                    end
                    if (exp_q.size() != 0) begin
                        mw = exp_q.pop_front();
                        chk("sb_data", 64'(out_data), 64'(mw.data));
                        chk("sb_keep", 64'(out_keep), 64'(mw.keep));
                        chk("sb_last", 64'(out_last), 64'(mw.last));
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_keep",  64'(out_keep),  64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_word_cnt",  64'(word_cnt),  64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Full word with in_last on the final byte
        send(8'h04, 0); send(8'h03, 0); send(8'h02, 0); send(8'h01, 1);
        chk("t1_latency",  64'(out_valid), 64'd1);
        chk("t1_out_data", 64'(out_data),  64'h01020304);
        chk("t1_out_keep", 64'(out_keep),  64'hF);
        @(posedge clock);
        #1;
        chk("t1_word_cnt",  64'(word_cnt),  64'd1);
        chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("t1_frame_err", 64'(frame_err), 64'd0);
        chk("t1_drained",   64'(out_valid), 64'd0);

        // Short frame of 3 bytes
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
        chk("t2_out_data", 64'(out_data), 64'h00CCBBAA);
        chk("t2_out_keep", 64'(out_keep), 64'h7);
        @(posedge clock);
        #1;
        chk("t2_frame_err", 64'(frame_err), 64'(m_err));
        chk("t2_frame_cnt", 64'(frame_cnt), 64'd2);

        // Backpressure: hold for 20 cycles and lose no byte
        out_ready = 1'b0;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        chk("t3_hold_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        in_data  = 8'h05;
        in_last  = 1'b0;
        repeat (20) begin
            @(negedge clock);
            chk("t3_in_ready_low", 64'(in_ready), 64'd0);
            chk("t3_data_held",    64'(out_data), 64'h04030201);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 0);
        chk("t3_next_word", 64'(out_data), 64'h08070605);
        drain();
        chk("t3_word_cnt", 64'(word_cnt), 64'(m_words));

        // Continuous stream: one word every BYTES cycles
        hs_t.delete();
        for (int i = 0; i < 16; i++) send(8'(i), i == 15);
        drain();
        chk("t4_words", 64'(hs_t.size()), 64'd4);
        for (int i = 1; i < 4 && i < hs_t.size(); i++)
            chk("t4_spacing", 64'(hs_t[i] - hs_t[i-1]), 64'd40);
        chk("t4_frame_cnt", 64'(frame_cnt), 64'(m_frames));

        // Reset while a word is held, then reset in the middle of a word
        out_ready = 1'b0;
        send(8'hE1, 0); send(8'hE2, 0); send(8'hE3, 0); send(8'hE4, 0);
        chk("t5_hold_valid", 64'(out_valid), 64'd1);
        pulse_reset();
        out_ready = 1'b1;
        send(8'h5A, 0); send(8'h5B, 0);
        pulse_reset();
        chk("t5_rst_word_cnt", 64'(word_cnt), 64'd0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        chk("t5_out_data", 64'(out_data), 64'h44332211);
        drain();
        chk("t5_word_cnt",  64'(word_cnt),  64'd1);
        chk("t5_frame_err", 64'(frame_err), 64'd0);

        // Random in_valid gaps and out_ready backpressure
        pulse_reset();
        rnd = 1'b1;
        for (int w = 0; w < LIS_SIZE; w++) begin
            for (int b = 0; b < BYTES; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                send(8'($urandom), b == BYTES - 1);
            end
        end
        rnd = 1'b0;
        drain();
        chk("t6_word_cnt",  64'(word_cnt),  64'(LIS_SIZE));
        chk("t6_frame_cnt", 64'(frame_cnt), 64'(LIS_SIZE));
        chk("t6_frame_err", 64'(frame_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
